flag_ctx_stack: RTL

Parametrised flag unit for the SimpleRISC pipeline. It holds the architectural GT/EQ flag register, updates it from the ALU on a committed CMP, and saves/restores it across nested interrupts through an internal LIFO context stack, so no external flag_D_in path is needed. It sits at the writeback boundary and feeds the branch unit through a registered output and a same-cycle forwarding output.

---
 rtl/flag_ctx_stack.sv | 133 +++++++++++++
 1 files changed

// File: rtl/flag_ctx_stack.sv
// flag_ctx_stack: architectural GT/EQ flag register with an internal LIFO
// context stack that saves and restores flags across nested interrupts.
// flags_fwd is the combinational next value, used as a zero-cycle forwarding
// path to the branch unit. flags_out is the registered copy.
module flag_ctx_stack #(
  parameter int               FLAG_W  = 2,
  parameter int               DEPTH   = 4,
  parameter int               OPC_W   = 5,
  parameter logic [OPC_W-1:0] CMP_OPC = 5'b00101
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         valid,
  input  logic [OPC_W-1:0]             opcode,
  input  logic [FLAG_W-1:0]            flags_in,
  input  logic                         irq_entry,
  input  logic                         iret,
  input  logic                         err_clr,
  output logic [FLAG_W-1:0]            flags_out,
  output logic                         gt_flag,
  output logic                         eq_flag,
  output logic [FLAG_W-1:0]            flags_fwd,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [FLAG_W-1:0] stack_q [DEPTH];

  logic              emptyNow;
  logic              fullNow;
  logic              cmpHit;
  logic              doPush;
  logic              doPop;
  logic              pushWrite;
  logic              clrErr;
  logic [AW-1:0]     wrIdx;
  logic [AW-1:0]     topIdx;
  logic [FLAG_W-1:0] topEntry;

  assign emptyNow  = (depth_q == '0);
  assign fullNow   = (depth_q == DW'(DEPTH));
  assign cmpHit    = valid & (opcode == CMP_OPC) & ~stall;
  // irq_entry together with iret is a tail-chain: pop then re-push of the
  // same entry, so the stack and depth stay as they are.
  assign doPush    = irq_entry & ~iret & ~stall;
  assign doPop     = iret & ~irq_entry & ~stall;
  assign pushWrite = doPush & ~fullNow;
  assign clrErr    = err_clr & ~stall;

  // The stack is indexed directly by depth; the top entry lives one below.
  // topIdx is only meaningful while the stack is non-empty.
  assign wrIdx    = depth_q[AW-1:0];
  assign topIdx   = wrIdx - AW'(1);
  assign topEntry = stack_q[topIdx];

  // Next flag value: a return restores the saved context and overrides any
  // CMP committing in the same cycle; a return on an empty stack holds.
  always_comb begin
    flags_d = flags_q;
    if (!stall) begin
      if (iret) begin
        if (!emptyNow) begin
          flags_d = topEntry;
        end
      end else if (cmpHit) begin
        flags_d = flags_in;
      end
    end
  end

  // Occupancy saturates: a push while full and a pop while empty leave it alone.
  always_comb begin
    depth_d = depth_q;
    if (doPush && !fullNow) begin
      depth_d = depth_q + DW'(1);
    end else if (doPop && !emptyNow) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Sticky errors: a new error in the same cycle as err_clr keeps the bit set.
  assign ovf_d = (doPush & fullNow) | (ovf_q & ~clrErr);
  assign unf_d = (iret & ~stall & emptyNow) | (unf_q & ~clrErr);

  // Flag, occupancy and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Context stack storage; a push saves the post-CMP value so the handler and
  // the saved context agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (pushWrite) begin
      stack_q[wrIdx] <= flags_d;
    end
  end

  assign flags_out   = flags_q;
  assign gt_flag     = flags_q[1];
  assign eq_flag     = flags_q[0];
  assign flags_fwd   = flags_d;
  assign depth       = depth_q;
  assign stack_full  = fullNow;
  assign stack_empty = emptyNow;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
